// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port storage array for the FIFO. Synchronous
//               write port, asynchronous (combinational) read port so the
//               head word can be presented first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // Contents are never reset; validity is tracked by the pointers outside.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read keeps the head word visible without a read cycle.
    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fifo_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wrapper
// Description : Single-clock FWFT FIFO with valid/ready handshakes on both
//               sides. Pointers carry one extra wrap bit so that all DEPTH
//               entries are usable and full/empty are unambiguous.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wrapper #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_data,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] output_data,
    output logic             output_valid,
    input  logic             output_ready
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // Flags depend only on the pointers, never on the handshake inputs.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    assign input_ready  = !w_full;
    assign output_valid = !w_empty;

    assign w_push = input_valid  && input_ready;
    assign w_pop  = output_valid && output_ready;

    // Advance the pointers on accepted transfers; wrap is natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .wr_data (input_data),
        .rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .rd_data (output_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wrapper
// Description : Scoreboard bench for fifo_wrapper. Stimulus pushes accepted
//               words into an expected queue; a monitor on the falling edge
//               compares the presented head word and the flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wrapper;

    localparam int WIDTH = 8;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] input_data = '0;
    logic             input_valid = 1'b0;
    logic             input_ready;
    logic [WIDTH-1:0] output_data;
    logic             output_valid;
    logic             output_ready = 1'b0;

    logic [WIDTH-1:0] exp_q [$];
    int               n_cmp  = 0;
    int               n_bad  = 0;
    int               n_pops = 0;
    logic             mon_en = 1'b0;

    fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, decide at the falling edge whether the
    // push will be accepted, and record it in the model at the rising edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic accepted;
        input_valid  = v;
        input_data   = d;
        output_ready = r;
        @(negedge clk);
        accepted = v && input_ready;
        @(posedge clk);
        if (accepted) exp_q.push_back(d);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_budget", 32'(exp_q.size()), 32'd0);
        output_ready = 1'b0;
    endtask

    // Monitor: compare flags against model occupancy and the head word.
    always @(negedge clk) begin
        if (reset && mon_en) begin
            check("output_valid_vs_model", 32'(output_valid), 32'(exp_q.size() != 0));
            check("input_ready_vs_model", 32'(input_ready), 32'(exp_q.size() < DEPTH));
            if (output_valid && exp_q.size() != 0) begin
                check("output_data", 32'(output_data), 32'(exp_q[0]));
                if (output_ready) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    initial begin
        int base;
        // Reset and idle
        reset = 1'b0;
        #1;
        check("reset_valid", 32'(output_valid), 32'd0);
        check("reset_ready", 32'(input_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0);
        check("idle_valid", 32'(output_valid), 32'd0);
        check("idle_ready", 32'(input_ready), 32'd1);

        // Single word 0xA5 held for five cycles, then popped
        step(1'b1, 8'hA5, 1'b0);
        check("a5_valid", 32'(output_valid), 32'd1);
        check("a5_data", 32'(output_data), 32'hA5);
        repeat (5) step(1'b0, '0, 1'b0);
        check("a5_hold_valid", 32'(output_valid), 32'd1);
        check("a5_hold_data", 32'(output_data), 32'hA5);
        step(1'b0, '0, 1'b1);
        check("a5_popped_valid", 32'(output_valid), 32'd0);

        // Fill to DEPTH, reject overflow word
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", 32'(input_ready), 32'd1);
            step(1'b1, 8'(i), 1'b0);
        end
        check("full_ready", 32'(input_ready), 32'd0);
        step(1'b1, 8'hFF, 1'b0);
        check("overflow_ready", 32'(input_ready), 32'd0);
        check("overflow_depth", 32'(exp_q.size()), 32'(DEPTH));
        // Full with push+pop offered: only the pop happens
        base = n_pops;
        step(1'b1, 8'hEE, 1'b1);
        check("full_pushpop_ready", 32'(input_ready), 32'd1);
        check("full_pushpop_pops", 32'(n_pops - base), 32'd1);
        check("full_pushpop_occ", 32'(exp_q.size()), 32'(DEPTH - 1));
        check("full_head", 32'(output_data), 32'h01);
        base = n_pops;
        drain(DEPTH + 10);
        check("drain_count", 32'(n_pops - base), 32'(DEPTH - 1));

        // Continuous streaming: pointers wrap twice
        base = n_pops;
        for (int c = 0; c < 300; c++) step(1'b1, 8'(c), 1'b1);
        check("stream_occ", 32'(exp_q.size()), 32'd1);
        drain(10);
        check("stream_count", 32'(n_pops - base), 32'd300);

        // Reset mid-operation discards contents immediately
        repeat (3) step(1'b1, 8'h5A, 1'b0);
        check("pre_reset_valid", 32'(output_valid), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_valid", 32'(output_valid), 32'd0);
        check("midreset_ready", 32'(input_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, '0, 1'b1);
        check("post_reset_valid", 32'(output_valid), 32'd0);

        // Randomised handshakes on both sides
        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain(DEPTH + 10);
        check("final_empty", 32'(output_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fifo_wrapper.md
Name: fifo_wrapper

Overview:
- Synchronous single-clock FIFO with valid/ready handshakes on both sides.
- Used in pairs around the decoder top: one buffers the 8-bit host-to-decoder command/measurement byte stream, the other buffers the decoder-to-host result byte stream (iteration count, cycle count, etc.).
- Provides rate decoupling and backpressure, and presents data first-word-fall-through (FWFT) to the consumer.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 128, number of storage entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- input_data  input  WIDTH  write-side data word.
- input_valid  input  1  producer offers input_data this cycle.
- input_ready  output  1  FIFO can accept a word this cycle.
- output_data  output  WIDTH  head-of-queue word, valid when output_valid=1.
- output_valid  output  1  FIFO holds at least one word.
- output_ready  input  1  consumer takes the head word this cycle.

Behaviour:
- Internal state:
  - Storage array mem[DEPTH] of WIDTH bits.
  - Write pointer wr_ptr and read pointer rd_ptr, each ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)); the extra MSB is the wrap bit.
- Status:
  - empty when wr_ptr == rd_ptr.
  - full when the low ADDR_W bits are equal and the MSBs differ.
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, so output_valid=0 and input_ready=1 immediately. Storage contents are not reset.
- Handshake rules:
  - input_ready = !full; output_valid = !empty. Both are combinational from the pointers only, with no dependence on valid/ready inputs.
  - push = input_valid & input_ready. On the rising edge: mem[wr_ptr[ADDR_W-1:0]] <= input_data; wr_ptr <= wr_ptr+1.
  - pop = output_valid & output_ready. On the rising edge: rd_ptr <= rd_ptr+1.
  - output_data = mem[rd_ptr[ADDR_W-1:0]] (FWFT, combinational read). Value is don't-care while output_valid=0.
- Latency:
  - A word pushed at edge N appears with output_valid=1 in the cycle after edge N (one-cycle write-to-read latency).
  - There is no same-cycle pass-through when empty.
- Simultaneous push and pop:
  - Both occur; occupancy is unchanged.
  - Permitted whenever neither full nor empty.
  - When full, push is blocked (input_ready=0) even if a pop occurs that cycle.
  - When empty, pop is blocked (output_valid=0) even if a push occurs that cycle.
- Wrap-around: pointers increment modulo 2^(ADDR_W+1), with natural overflow.
- Ordering and integrity: strict first-in first-out; no word is lost or duplicated.
- Ignored inputs: input_valid while full has no effect; output_ready while empty has no effect.
- Stability: output_data and output_valid stay stable while output_valid=1 and output_ready=0.
- Reset mid-operation: contents are discarded. The FIFO reads empty from the cycle reset asserts until the first push after reset deasserts.
- Occupancy range is 0..DEPTH; all DEPTH entries are usable.

Decomposition:
- No shared package required. The only derived constant, ADDR_W, is a localparam.
- One natural sub-module: fifo_ram, a simple dual-port array with a synchronous write port and an asynchronous read port, parameterised by WIDTH and DEPTH.
- Pointer and flag logic stays in fifo_wrapper.

Test Plan:
- Reset, then idle -> output_valid=0, input_ready=1; asserting reset=0 mid-run clears occupancy immediately.
- Push 0xA5 (input_valid=1 for one cycle), output_ready=0 -> output_valid=1 in the next cycle with output_data=0xA5; it holds for 5 cycles; one cycle with output_ready=1 -> output_valid=0.
- Push 128 words 0x00..0x7F with no pops -> input_ready=0 after the 128th push; a 129th word (0xFF) is not stored; draining yields exactly 0x00..0x7F in order.
- Full FIFO with input_valid=1 and output_ready=1 together -> one pop and no push; next cycle input_ready=1 with occupancy 127.
- Continuous streaming with input_valid=1 and output_ready=1 for 300 cycles, data = cycle index mod 256 -> after the first-word latency, one word out per cycle, in order; pointers wrap twice with no loss.
- Randomised valid/ready on both sides for 10,000 cycles against a scoreboard queue -> every output equals the expected head, and there is never output_valid=1 when the model is empty or input_ready=1 when the model is full.
